// File: rtl/fp_operand_sequencer.sv
// Self-running operand-pair generator for the FP add/sub datapath.
// Corner sweep, free random, constrained random and ordered random runs.
module fp_operand_sequencer #(
  parameter int          WIDTH     = 32,
  parameter int          EXP_BITS  = 8,
  parameter int          MANT_BITS = 23,
  parameter logic [31:0] LFSR_SEED = 32'h1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [15:0]      num_vectors,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             operation_select,
  output logic [15:0]      vec_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] M_CORNER  = 2'd0;
  localparam logic [1:0] M_RANDOM  = 2'd1;
  localparam logic [1:0] M_CUSTOM  = 2'd2;
  localparam logic [1:0] M_ORDERED = 2'd3;

  localparam logic [31:0] POLY = 32'h8020_0003;
  localparam logic [31:0] SEED =
    (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

  // op bit sits just above the operand; wraps to bit 0 at full width
  localparam int OPB = WIDTH % 32;

  localparam logic [EXP_BITS-1:0] E_ZERO = '0;
  localparam logic [EXP_BITS-1:0] E_ONES = '1;
  localparam logic [EXP_BITS-1:0] E_MAX =
    {{(EXP_BITS-1){1'b1}}, 1'b0};
  localparam logic [EXP_BITS-1:0] E_ONE =
    {{(EXP_BITS-1){1'b0}}, 1'b1};

  localparam logic [MANT_BITS-1:0] M_ZERO = '0;
  localparam logic [MANT_BITS-1:0] M_ONES = '1;
  localparam logic [MANT_BITS-1:0] M_MSB =
    {1'b1, {(MANT_BITS-1){1'b0}}};
  localparam logic [MANT_BITS-1:0] M_ONE =
    {{(MANT_BITS-1){1'b0}}, 1'b1};

  localparam logic [WIDTH-1:0] ONE_W =
    {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [1:0]       mode_q;
  logic [15:0]      len_q;
  logic [31:0]      lfsr;
  logic [31:0]      lfsr_rev;
  logic [31:0]      lfsr_nxt;
  logic [WIDTH-1:0] a_n;
  logic [WIDTH-1:0] b_n;
  logic             op_n;
  logic             hs;
  logic             last;

  function automatic logic [WIDTH-1:0] corner(
    input logic [2:0] c
  );
    logic [WIDTH-1:0] v;
    case (c)
      3'd0:    v = {1'b0, E_ZERO, M_ZERO};
      3'd1:    v = {1'b0, E_ONES, M_MSB};
      3'd2:    v = {1'b0, E_ONES, M_ZERO};
      3'd3:    v = {1'b1, E_ONES, M_ZERO};
      3'd4:    v = {1'b0, E_MAX, M_ONES};
      3'd5:    v = {1'b1, E_MAX, M_ONES};
      3'd6:    v = {1'b0, E_ONE, M_ZERO};
      default: v = {1'b0, E_ZERO, M_ONE};
    endcase
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] custom(
    input logic [1:0] el,
    input logic [2:0] mh
  );
    logic [EXP_BITS-1:0]  e;
    logic [MANT_BITS-1:0] m;
    e = '0;
    e[EXP_BITS-1] = 1'b1;
    e[1:0] = el;
    m = '0;
    m[MANT_BITS-1 -: 3] = mh;
    return {1'b0, e, m};
  endfunction

  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign out_valid = busy;
  assign hs        = busy && out_ready;
  assign last      = (vec_idx == len_q - 16'd1);
  assign lfsr_nxt  = {1'b0, lfsr[31:1]}
                   ^ (lfsr[0] ? POLY : 32'h0);

  assign a                = busy ? a_n : '0;
  assign b                = busy ? b_n : '0;
  assign operation_select = busy & op_n;

  // bit-reversed view of the LFSR feeds operand B
  always_comb begin
    lfsr_rev = '0;
    for (int i = 0; i < 32; i++) begin
      lfsr_rev[i] = lfsr[31-i];
    end
  end

  // pick the vector for the latched mode
  always_comb begin
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    x    = lfsr[WIDTH-1:0];
    y    = lfsr_rev[WIDTH-1:0];
    a_n  = x;
    b_n  = y;
    op_n = lfsr[OPB];
    unique case (1'b1)
      mode_q == M_CORNER: begin
        a_n  = corner(vec_idx[6:4]);
        b_n  = corner(vec_idx[3:1]);
        op_n = vec_idx[0];
      end
      mode_q == M_CUSTOM: begin
        a_n  = custom(lfsr[1:0], lfsr[4:2]);
        b_n  = custom(lfsr[9:8], lfsr[12:10]);
        op_n = lfsr[16];
      end
      mode_q == M_ORDERED: begin
        if (x > y) begin
          a_n = x;
          b_n = y;
        end else if (x < y) begin
          a_n = y;
          b_n = x;
        end else begin
          a_n = x | ONE_W;
          b_n = x & ~ONE_W;
        end
      end
      default: begin
        a_n = x;
        b_n = y;
      end
    endcase
  end

  // run control, vector counter and LFSR stepping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      mode_q  <= M_CORNER;
      len_q   <= 16'd0;
      vec_idx <= 16'd0;
      lfsr    <= SEED;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            vec_idx <= 16'd0;
            len_q   <= (mode == M_CORNER) ? 16'd128
                                          : num_vectors;
            if (mode != M_CORNER && num_vectors == 16'd0)
              state <= S_DONE;
            else
              state <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            state   <= S_IDLE;
            vec_idx <= 16'd0;
          end else if (hs) begin
            if (mode_q != M_CORNER)
              lfsr <= lfsr_nxt;
            if (last) begin
              state   <= S_DONE;
              vec_idx <= 16'd0;
            end else begin
              vec_idx <= vec_idx + 16'd1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_operand_sequencer.sv
// Directed bench for fp_operand_sequencer.
// Corner sweep, random modes, backpressure, abort and reset.
module tb_fp_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] num_vectors;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        operation_select;
  logic [15:0] vec_idx;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] lfsr_m = 32'h1;
  logic [31:0] hash;
  logic [31:0] hash1;
  logic [31:0] cls [8];

  fp_operand_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .mode             (mode),
    .num_vectors      (num_vectors),
    .abort            (abort),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .a                (a),
    .b                (b),
    .operation_select (operation_select),
    .vec_idx          (vec_idx),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  function automatic logic [31:0] lfsr_step(
    input logic [31:0] s
  );
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic void exp_vec(
    input  logic [1:0]  md,
    input  logic [31:0] l,
    output logic [31:0] ea,
    output logic [31:0] eb,
    output logic        eo
  );
    logic [31:0] r;
    r  = {<<{l}};
    ea = l;
    eb = r;
    eo = l[0];
    if (md == 2'd2) begin
      ea = {1'b0, 6'b100000, l[1:0], l[4:2], 20'd0};
      eb = {1'b0, 6'b100000, l[9:8], l[12:10], 20'd0};
      eo = l[16];
    end else if (md == 2'd3) begin
      if (l > r) begin
        ea = l; eb = r;
      end else if (l < r) begin
        ea = r; eb = l;
      end else begin
        ea = l | 32'h1; eb = l & ~32'h1;
      end
    end
  endfunction

  function automatic logic custom_ok(input logic [31:0] v);
    return v[31] == 1'b0 && v[30:25] == 6'b100000
        && v[19:0] == 20'd0;
  endfunction

  task automatic run_corner(
    input int stall_at,
    input int stall_len
  );
    int k = 0;
    int st = 0;
    bit fin = 0;
    logic [6:0] kv;
    @(negedge clk);
    mode = 2'd0; num_vectors = 16'd5;
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 1000 && !fin; cyc++) begin
      if (done) begin
        chk("corner_count", k, 128);
        chk("corner_done_cyc", cyc, 129 + stall_len);
        fin = 1;
      end else if (!out_valid) begin
        chk("corner_valid", out_valid, 1);
        fin = 1;
      end else begin
        kv = k[6:0];
        chk("corner_a", a, cls[kv[6:4]]);
        chk("corner_b", b, cls[kv[3:1]]);
        chk("corner_op", operation_select, kv[0]);
        chk("corner_idx", vec_idx, k);
        if (k == stall_at && st < stall_len) begin
          out_ready = 1'b0; st++;
        end else begin
          out_ready = 1'b1; k++;
        end
      end
      if (!fin) @(negedge clk);
    end
    chk("corner_finished", fin, 1);
    if (fin && done) begin
      @(negedge clk);
      chk("corner_done_pulse", done, 0);
      chk("corner_busy_end", busy, 0);
    end
    out_ready = 1'b1;
  endtask

  task automatic run_rand(
    input logic [1:0] md,
    input int         n,
    input int         abort_at,
    input int         rst_at,
    input bit         poke
  );
    int k = 0;
    bit fin = 0;
    bit saw_done = 0;
    logic [31:0] ea, eb;
    logic eo;
    hash = 32'h0;
    @(negedge clk);
    mode = md; num_vectors = n[15:0];
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 3000 && !fin; cyc++) begin
      if (done) begin
        chk("rand_count", k, n);
        chk("rand_done_valid", out_valid, 0);
        fin = 1; saw_done = 1;
      end else if (!out_valid) begin
        chk("rand_valid", out_valid, 1);
        fin = 1;
      end else begin
        exp_vec(md, lfsr_m, ea, eb, eo);
        chk("rand_a", a, ea);
        chk("rand_b", b, eb);
        chk("rand_op", operation_select, eo);
        chk("rand_idx", vec_idx, k);
        if (md == 2'd3) chk("ord_gt", a > b, 1);
        if (md == 2'd2)
          chk("custom_fmt", custom_ok(a) && custom_ok(b), 1);
        if (k == abort_at) begin
          abort = 1'b1; out_ready = 1'b1;
          @(negedge clk);
          chk("abort_valid", out_valid, 0);
          chk("abort_busy", busy, 0);
          chk("abort_idx", vec_idx, 0);
          chk("abort_done", done, 0);
          @(negedge clk);
          chk("abort_idle_valid", out_valid, 0);
          chk("abort_idle_done", done, 0);
          abort = 1'b0;
          fin = 1;
        end else if (k == rst_at) begin
          #2 rst = 1'b1;
          #1;
          chk("rst_valid", out_valid, 0);
          chk("rst_a", a, 0);
          chk("rst_b", b, 0);
          chk("rst_idx", vec_idx, 0);
          chk("rst_busy", busy, 0);
          @(negedge clk);
          chk("rst_done", done, 0);
          rst = 1'b0;
          lfsr_m = 32'h1;
          fin = 1;
        end else begin
          start = poke && k == 3;
          if (poke && k == 3) mode = 2'd0;
          else mode = md;
          out_ready = (cyc % 5) != 2;
          if (out_ready) begin
            hash = {hash[30:0], hash[31]} ^ a ^ b;
            lfsr_m = lfsr_step(lfsr_m);
            k++;
          end
        end
      end
      if (!fin) @(negedge clk);
    end
    start = 1'b0;
    chk("rand_finished", fin, 1);
    if (saw_done) begin
      @(negedge clk);
      chk("rand_done_pulse", done, 0);
      chk("rand_busy_end", busy, 0);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    cls[0] = 32'h0000_0000; cls[1] = 32'h7FC0_0000;
    cls[2] = 32'h7F80_0000; cls[3] = 32'hFF80_0000;
    cls[4] = 32'h7F7F_FFFF; cls[5] = 32'hFF7F_FFFF;
    cls[6] = 32'h0080_0000; cls[7] = 32'h0000_0001;
    rst = 1'b1; start = 1'b0; mode = 2'd0;
    num_vectors = 16'd0; abort = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", out_valid, 0);
    chk("reset_a", a, 0);
    chk("reset_b", b, 0);
    chk("reset_op", operation_select, 0);
    chk("reset_idx", vec_idx, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;

    run_corner(-1, 0);
    run_corner(10, 5);

    run_rand(2'd1, 20, -1, -1, 1'b1);

    @(negedge clk);
    mode = 2'd1; num_vectors = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_valid", out_valid, 0);
    chk("zero_busy", busy, 0);
    @(negedge clk);
    chk("zero_done_end", done, 0);
    chk("zero_valid_end", out_valid, 0);

    run_rand(2'd2, 64, -1, -1, 1'b0);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lfsr_m = 32'h1;
    run_rand(2'd3, 1000, -1, -1, 1'b0);
    hash1 = hash;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lfsr_m = 32'h1;
    run_rand(2'd3, 1000, -1, -1, 1'b0);
    chk("ord_repeat", hash, hash1);

    run_rand(2'd1, 20, 7, -1, 1'b0);
    run_rand(2'd1, 50, -1, 5, 1'b0);
    run_rand(2'd1, 8, -1, -1, 1'b0);
    run_corner(-1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
